// File: rtl/mem_rtl_pkg.sv
// Shared types and parameter sanity checks for the multi-port RAM model.
package mem_rtl_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ClrState_t;

   function automatic bit paramsOk(input int wordSize, input int numWords,
                                   input int numRports, input int readLat);
      return (wordSize > 0) && (wordSize % 8 == 0) && (numWords >= 2) &&
             (numRports >= 1) && (numRports <= 4) &&
             (readLat >= 1) && (readLat <= 3);
   endfunction

endpackage

// File: rtl/mem_rtl_rdpipe.sv
// Fixed-depth delay line carrying a read result with its valid flag.
module mem_rtl_rdpipe #(
   parameter int DEPTH = 0,
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_d
);

   if (DEPTH == 0) begin : g_bypass
      logic w_unusedClkRst;
      assign w_unusedClkRst = clk ^ rst;
      assign o_d = i_d;
   end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
         end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
         end
      end

      assign o_d = r_stage[DEPTH-1];
   end

endmodule

// File: rtl/mem_rtl_mp.sv
// Multi-port byte-maskable synchronous RAM: one read/write port, NUM_RPORTS
// read-only ports, registered requests, configurable read latency and clear.
module mem_rtl_mp
   import mem_rtl_pkg::*;
#(
   parameter int WORD_SIZE      = 32,
   parameter int NUM_WORDS      = 1024,
   parameter int NUM_RPORTS     = 1,
   parameter int READ_LAT       = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int AW = $clog2(NUM_WORDS),
   localparam int NB = WORD_SIZE / 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            IN_nce,
   input  logic                            IN_nwe,
   input  logic [AW-1:0]                   IN_addr,
   input  logic [WORD_SIZE-1:0]            IN_data,
   input  logic [NB-1:0]                   IN_wm,
   output logic [WORD_SIZE-1:0]            OUT_data,
   output logic                            OUT_valid,
   input  logic [NUM_RPORTS-1:0]           IN_rnce,
   input  logic [NUM_RPORTS*AW-1:0]        IN_raddr,
   output logic [NUM_RPORTS*WORD_SIZE-1:0] OUT_rdata,
   output logic [NUM_RPORTS-1:0]           OUT_rvalid,
   output logic                            OUT_ready
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_WORDS - 1);

   if (!paramsOk(WORD_SIZE, NUM_WORDS, NUM_RPORTS, READ_LAT)) begin : g_badParams
      $error("mem_rtl_mp: illegal parameter combination");
   end

   ClrState_t                           r_state;
   logic [AW:0]                         r_clrIdx;
   logic                                r_ready;
   logic                                r_nce;
   logic                                r_nwe;
   logic [AW-1:0]                       r_addr;
   logic [WORD_SIZE-1:0]                r_data;
   logic [NB-1:0]                       r_wm;
   logic [NUM_RPORTS-1:0]               r_rnce;
   logic [NUM_RPORTS-1:0][AW-1:0]       r_raddr;
   logic [WORD_SIZE-1:0]                r_mem [NUM_WORDS];
   logic [WORD_SIZE-1:0]                r_s1Data;
   logic                                r_s1Valid;
   logic [NUM_RPORTS-1:0][WORD_SIZE-1:0] r_s1RData;
   logic [NUM_RPORTS-1:0]               r_s1RValid;

   logic                                w_accept;
   logic                                w_wrEn;
   logic                                w_rdEn;
   logic [WORD_SIZE-1:0]                w_merged;
   logic [NUM_RPORTS-1:0][WORD_SIZE-1:0] w_rdWord;
   logic [WORD_SIZE:0]                  w_p0Out;
   logic [NUM_RPORTS-1:0][WORD_SIZE:0]  w_rOut;

   // Clear sequencer: one zero write per cycle, READY is terminal until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         r_clrIdx <= '0;
         r_ready  <= (CLEAR_ON_RESET == 0);
      end else if (r_state == CLEAR) begin
         r_clrIdx <= r_clrIdx + 1'b1;
         if (r_clrIdx == LAST_IDX) begin
            r_state <= READY;
            r_ready <= 1'b1;
         end
      end
   end

   assign w_accept  = (r_state == READY);
   assign OUT_ready = r_ready;

   // Requests captured while clearing are forced inactive here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nce   <= 1'b1;
         r_nwe   <= 1'b1;
         r_addr  <= '0;
         r_data  <= '0;
         r_wm    <= '0;
         r_rnce  <= '1;
         r_raddr <= '0;
      end else begin
         r_nce   <= IN_nce | ~w_accept;
         r_nwe   <= IN_nwe;
         r_addr  <= IN_addr;
         r_data  <= IN_data;
         r_wm    <= IN_wm;
         r_rnce  <= IN_rnce | {NUM_RPORTS{~w_accept}};
         r_raddr <= IN_raddr;
      end
   end

   assign w_wrEn = ~r_nce & ~r_nwe;
   assign w_rdEn = ~r_nce &  r_nwe;

   always_comb begin
      w_merged = r_mem[r_addr];
      for (int b = 0; b < NB; b++) begin
         if (r_wm[b]) w_merged[b*8 +: 8] = r_data[b*8 +: 8];
      end
   end

   // Write-first forwarding of the merged word to colliding read ports.
   always_comb begin
      for (int k = 0; k < NUM_RPORTS; k++) begin
         w_rdWord[k] = r_mem[r_raddr[k]];
         if ((WRITE_FIRST != 0) && w_wrEn && (r_raddr[k] == r_addr)) w_rdWord[k] = w_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == CLEAR) r_mem[r_clrIdx[AW-1:0]] <= '0;
      else if (w_wrEn)      r_mem[r_addr] <= w_merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Data   <= '0;
         r_s1Valid  <= 1'b0;
         r_s1RData  <= '0;
         r_s1RValid <= '0;
      end else begin
         r_s1Valid <= w_rdEn;
         if (w_rdEn) r_s1Data <= r_mem[r_addr];
         for (int k = 0; k < NUM_RPORTS; k++) begin
            r_s1RValid[k] <= ~r_rnce[k];
            if (!r_rnce[k]) r_s1RData[k] <= w_rdWord[k];
         end
      end
   end

   mem_rtl_rdpipe #(.DEPTH(READ_LAT - 1), .WIDTH(WORD_SIZE + 1)) u_p0Pipe (
      .clk (clk),
      .rst (rst),
      .i_d ({r_s1Valid, r_s1Data}),
      .o_d (w_p0Out)
   );

   assign OUT_data  = w_p0Out[WORD_SIZE-1:0];
   assign OUT_valid = w_p0Out[WORD_SIZE];

   for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
      mem_rtl_rdpipe #(.DEPTH(READ_LAT - 1), .WIDTH(WORD_SIZE + 1)) u_rPipe (
         .clk (clk),
         .rst (rst),
         .i_d ({r_s1RValid[k], r_s1RData[k]}),
         .o_d (w_rOut[k])
      );
      assign OUT_rdata[k*WORD_SIZE +: WORD_SIZE] = w_rOut[k][WORD_SIZE-1:0];
      assign OUT_rvalid[k]                       = w_rOut[k][WORD_SIZE];
   end

endmodule

// File: tb/tb_mem_rtl_mp.sv
// Directed bench for mem_rtl_mp: three latency/collision variants sharing
// one stimulus, plus a no-clear variant for the reset value of OUT_ready.
module tb_mem_rtl_mp;

   localparam int HIST = 512;

   logic        clk;
   logic        rst;
   logic        nce;
   logic        nwe;
   logic [3:0]  addr;
   logic [31:0] data;
   logic [3:0]  wm;
   logic [2:0]  rnce;
   logic [11:0] raddr;

   logic [31:0] oData   [4];
   logic        oValid  [4];
   logic [95:0] oRData  [4];
   logic [2:0]  oRValid [4];
   logic        oReady  [4];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;
   int lat [3] = '{1, 2, 3};
   int wf  [3] = '{0, 1, 0};

   logic        hValid  [3][HIST];
   logic [31:0] hData   [3][HIST];
   logic [2:0]  hRValid [3][HIST];
   logic [95:0] hRData  [3][HIST];
   logic        hReady  [4][HIST];

   mem_rtl_mp #(.WORD_SIZE(32), .NUM_WORDS(16), .NUM_RPORTS(3), .READ_LAT(1),
                .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .rst(rst), .IN_nce(nce), .IN_nwe(nwe), .IN_addr(addr), .IN_data(data),
      .IN_wm(wm), .OUT_data(oData[0]), .OUT_valid(oValid[0]), .IN_rnce(rnce),
      .IN_raddr(raddr), .OUT_rdata(oRData[0]), .OUT_rvalid(oRValid[0]), .OUT_ready(oReady[0]));

   mem_rtl_mp #(.WORD_SIZE(32), .NUM_WORDS(16), .NUM_RPORTS(3), .READ_LAT(2),
                .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .rst(rst), .IN_nce(nce), .IN_nwe(nwe), .IN_addr(addr), .IN_data(data),
      .IN_wm(wm), .OUT_data(oData[1]), .OUT_valid(oValid[1]), .IN_rnce(rnce),
      .IN_raddr(raddr), .OUT_rdata(oRData[1]), .OUT_rvalid(oRValid[1]), .OUT_ready(oReady[1]));

   mem_rtl_mp #(.WORD_SIZE(32), .NUM_WORDS(16), .NUM_RPORTS(3), .READ_LAT(3),
                .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut2 (
      .clk(clk), .rst(rst), .IN_nce(nce), .IN_nwe(nwe), .IN_addr(addr), .IN_data(data),
      .IN_wm(wm), .OUT_data(oData[2]), .OUT_valid(oValid[2]), .IN_rnce(rnce),
      .IN_raddr(raddr), .OUT_rdata(oRData[2]), .OUT_rvalid(oRValid[2]), .OUT_ready(oReady[2]));

   mem_rtl_mp #(.WORD_SIZE(32), .NUM_WORDS(16), .NUM_RPORTS(3), .READ_LAT(1),
                .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) dut3 (
      .clk(clk), .rst(rst), .IN_nce(nce), .IN_nwe(nwe), .IN_addr(addr), .IN_data(data),
      .IN_wm(wm), .OUT_data(oData[3]), .OUT_valid(oValid[3]), .IN_rnce(rnce),
      .IN_raddr(raddr), .OUT_rdata(oRData[3]), .OUT_rvalid(oRValid[3]), .OUT_ready(oReady[3]));

   // Free-running clock and a cycle counter that advances on every rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Output history, sampled mid-cycle and indexed by the cycle number.
   always @(negedge clk) begin
      if (cyc < HIST) begin
         for (int d = 0; d < 3; d++) begin
            hValid[d][cyc]  = oValid[d];
            hData[d][cyc]   = oData[d];
            hRValid[d][cyc] = oRValid[d];
            hRData[d][cyc]  = oRData[d];
         end
         for (int d = 0; d < 4; d++) hReady[d][cyc] = oReady[d];
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setIdle();
      nce   = 1'b1;
      nwe   = 1'b1;
      addr  = '0;
      data  = '0;
      wm    = '0;
      rnce  = 3'b111;
      raddr = '0;
   endtask

   task automatic applyStimulus(input logic iNce, input logic iNwe, input logic [3:0] iAddr,
                                input logic [31:0] iData, input logic [3:0] iWm,
                                input logic [2:0] iRnce, input logic [11:0] iRaddr);
      nce   = iNce;
      nwe   = iNwe;
      addr  = iAddr;
      data  = iData;
      wm    = iWm;
      rnce  = iRnce;
      raddr = iRaddr;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] btbVal(input int a);
      case (a)
         1:       return 32'h1111_0001;
         2:       return 32'h2222_0002;
         default: return 32'h3333_0003;
      endcase
   endfunction

   // Reset values, exact clear duration, and requests ignored while clearing.
   task automatic test_reset();
      int r;
      logic seen;
      setIdle();
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total++;
         if (oData[d] !== 32'h0 || oValid[d] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_p0 dut%0d: got data=%h valid=%b expected data=0 valid=0", d, oData[d], oValid[d]);
         end
         total++;
         if (oRData[d] !== 96'h0 || oRValid[d] !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_rports dut%0d: got rdata=%h rvalid=%b expected 0/000", d, oRData[d], oRValid[d]);
         end
         total++;
         if (oReady[d] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready dut%0d: got %b expected 0", d, oReady[d]);
         end
      end
      total++;
      if (oReady[3] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_ready_noclear: got %b expected 1", oReady[3]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      r = cyc;
      nce = 1'b0; nwe = 1'b0; addr = 4'd3; data = 32'hFFFF_FFFF; wm = 4'hF;
      rnce = 3'b000; raddr = {4'd3, 4'd3, 4'd3};
      repeat (16) @(posedge clk);
      #1;
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (hReady[d][r+15] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_ready_early dut%0d: got %b expected 0", d, hReady[d][r+15]);
         end
         total++;
         if (hReady[d][r+16] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clear_ready_rise dut%0d: got %b expected 1", d, hReady[d][r+16]);
         end
         seen = 1'b0;
         for (int c = r; c <= r + 21; c++) seen = seen | hValid[d][c] | (|hRValid[d][c]);
         total++;
         if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_ignored_valid dut%0d: got %b expected 0", d, seen);
         end
      end
      total++;
      if (hReady[3][r+5] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL noclear_ready: got %b expected 1", hReady[3][r+5]);
      end
   endtask

   // Every word reads back zero after the clear, including the ignored write to addr 3.
   task automatic test_clear_reads();
      int n;
      int s;
      n = cyc;
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b0, 1'b1, 4'(i), 32'h0, 4'h0, 3'b000, {4'(15 - i), 4'(i), 4'(15 - i)});
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (hValid[d][n+lat[d]] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clrrd_pre dut%0d: got %b expected 0", d, hValid[d][n+lat[d]]);
         end
         for (int i = 0; i < 16; i++) begin
            s = n + i + 1 + lat[d];
            total++;
            if (hValid[d][s] !== 1'b1 || hData[d][s] !== 32'h0) begin
               bad++;
               $display("[TB] FAIL clrrd_p0 dut%0d addr%0d: got v=%b d=%h expected v=1 d=0", d, i, hValid[d][s], hData[d][s]);
            end
            total++;
            if (hRValid[d][s] !== 3'b111 || hRData[d][s] !== 96'h0) begin
               bad++;
               $display("[TB] FAIL clrrd_rp dut%0d addr%0d: got v=%b d=%h expected v=111 d=0", d, i, hRValid[d][s], hRData[d][s]);
            end
         end
         s = n + 17 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b0 || hRValid[d][s] !== 3'b000) begin
            bad++;
            $display("[TB] FAIL clrrd_post dut%0d: got v=%b rv=%b expected 0/000", d, hValid[d][s], hRValid[d][s]);
         end
      end
   endtask

   // Full write then partial-mask write to addr 5, read back on port 0 and read port 0.
   task automatic test_byte_mask();
      int n;
      int s;
      n = cyc;
      applyStimulus(1'b0, 1'b0, 4'd5, 32'hAABB_CCDD, 4'b1111, 3'b111, 12'h0);
      applyStimulus(1'b0, 1'b0, 4'd5, 32'h1122_3344, 4'b0101, 3'b111, 12'h0);
      applyStimulus(1'b0, 1'b1, 4'd5, 32'h0, 4'h0, 3'b110, {4'd0, 4'd0, 4'd5});
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         s = n + 2 + lat[d];
         total++;
         if (hValid[d][n+1+lat[d]] !== 1'b0 || hValid[d][s] !== 1'b0 || hData[d][s] !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mask_wrslot dut%0d: got v=%b,%b d=%h expected v=0,0 d=0", d, hValid[d][n+1+lat[d]], hValid[d][s], hData[d][s]);
         end
         s = n + 3 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b1 || hData[d][s] !== 32'hAA22_CC44) begin
            bad++;
            $display("[TB] FAIL mask_p0 dut%0d: got v=%b d=%h expected v=1 d=aa22cc44", d, hValid[d][s], hData[d][s]);
         end
         total++;
         if (hRValid[d][s] !== 3'b001 || hRData[d][s][31:0] !== 32'hAA22_CC44) begin
            bad++;
            $display("[TB] FAIL mask_rp0 dut%0d: got v=%b d=%h expected v=001 d=aa22cc44", d, hRValid[d][s], hRData[d][s][31:0]);
         end
      end
   endtask

   // Same-edge write/read collisions, read-after-write, zero-mask write and data hold.
   task automatic test_collision();
      int n;
      int s;
      logic [31:0] expCol;
      logic [31:0] expMask;
      n = cyc;
      applyStimulus(1'b0, 1'b0, 4'd9, 32'h1234_5678, 4'b1111, 3'b001, {4'd5, 4'd9, 4'd0});
      applyStimulus(1'b1, 1'b1, 4'd0, 32'h0, 4'h0, 3'b101, {4'd0, 4'd9, 4'd0});
      applyStimulus(1'b0, 1'b0, 4'd9, 32'hDEAD_BEEF, 4'b0011, 3'b110, {4'd0, 4'd0, 4'd9});
      applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 4'b0000, 3'b111, 12'h0);
      applyStimulus(1'b0, 1'b1, 4'd9, 32'h0, 4'h0, 3'b111, 12'h0);
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         expCol  = (wf[d] != 0) ? 32'h1234_5678 : 32'h0;
         expMask = (wf[d] != 0) ? 32'h1234_BEEF : 32'h1234_5678;
         s = n + 1 + lat[d];
         total++;
         if (hRValid[d][s] !== 3'b110 || hRData[d][s][63:32] !== expCol || hRData[d][s][95:64] !== 32'hAA22_CC44) begin
            bad++;
            $display("[TB] FAIL coll_full dut%0d: got v=%b p1=%h p2=%h expected v=110 p1=%h p2=aa22cc44", d, hRValid[d][s], hRData[d][s][63:32], hRData[d][s][95:64], expCol);
         end
         s = n + 2 + lat[d];
         total++;
         if (hRValid[d][s] !== 3'b010 || hRData[d][s][63:32] !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL coll_raw dut%0d: got v=%b p1=%h expected v=010 p1=12345678", d, hRValid[d][s], hRData[d][s][63:32]);
         end
         s = n + 3 + lat[d];
         total++;
         if (hRValid[d][s] !== 3'b001 || hRData[d][s][31:0] !== expMask) begin
            bad++;
            $display("[TB] FAIL coll_masked dut%0d: got v=%b p0=%h expected v=001 p0=%h", d, hRValid[d][s], hRData[d][s][31:0], expMask);
         end
         s = n + 5 + lat[d];
         total++;
         if (hValid[d][n+4+lat[d]] !== 1'b0 || hValid[d][s] !== 1'b1 || hData[d][s] !== 32'h1234_BEEF) begin
            bad++;
            $display("[TB] FAIL coll_zeromask dut%0d: got v=%b,%b d=%h expected v=0,1 d=1234beef", d, hValid[d][n+4+lat[d]], hValid[d][s], hData[d][s]);
         end
         s = n + 6 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b0 || hData[d][s] !== 32'h1234_BEEF) begin
            bad++;
            $display("[TB] FAIL coll_hold dut%0d: got v=%b d=%h expected v=0 d=1234beef", d, hValid[d][s], hData[d][s]);
         end
      end
   endtask

   // Three writes then three back-to-back reads on every port; results must be contiguous.
   task automatic test_back_to_back();
      int n;
      int s;
      logic [31:0] exp;
      n = cyc;
      for (int a = 1; a <= 3; a++)
         applyStimulus(1'b0, 1'b0, 4'(a), btbVal(a), 4'hF, 3'b111, 12'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 4'(i + 1), 32'h0, 4'h0, 3'b000,
                       {4'(((i + 2) % 3) + 1), 4'(((i + 1) % 3) + 1), 4'(i + 1)});
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         s = n + 3 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b0 || hData[d][s] !== 32'h1234_BEEF) begin
            bad++;
            $display("[TB] FAIL btb_pre dut%0d: got v=%b d=%h expected v=0 d=1234beef", d, hValid[d][s], hData[d][s]);
         end
         for (int i = 0; i < 3; i++) begin
            s = n + 4 + i + lat[d];
            total++;
            if (hValid[d][s] !== 1'b1 || hData[d][s] !== btbVal(i + 1)) begin
               bad++;
               $display("[TB] FAIL btb_p0 dut%0d slot%0d: got v=%b d=%h expected v=1 d=%h", d, i, hValid[d][s], hData[d][s], btbVal(i + 1));
            end
            total++;
            if (hRValid[d][s] !== 3'b111) begin
               bad++;
               $display("[TB] FAIL btb_rvalid dut%0d slot%0d: got %b expected 111", d, i, hRValid[d][s]);
            end
            for (int k = 0; k < 3; k++) begin
               exp = btbVal(((i + k) % 3) + 1);
               total++;
               if (hRData[d][s][k*32 +: 32] !== exp) begin
                  bad++;
                  $display("[TB] FAIL btb_rdata dut%0d slot%0d port%0d: got %h expected %h", d, i, k, hRData[d][s][k*32 +: 32], exp);
               end
            end
         end
         s = n + 7 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b0 || hRValid[d][s] !== 3'b000 || hData[d][s] !== btbVal(3)) begin
            bad++;
            $display("[TB] FAIL btb_post dut%0d: got v=%b rv=%b d=%h expected v=0 rv=000 d=33330003", d, hValid[d][s], hRValid[d][s], hData[d][s]);
         end
      end
   endtask

   // Reset with reads in flight: nothing emitted, OUT_ready drops, clear reruns from 0.
   task automatic test_mid_reset();
      int n;
      int r;
      int s;
      logic seen;
      n = cyc;
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h0, 4'h0, 3'b000, {4'd2, 4'd2, 4'd2});
      applyStimulus(1'b0, 1'b1, 4'd2, 32'h0, 4'h0, 3'b000, {4'd2, 4'd2, 4'd2});
      rst = 1'b1;
      setIdle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      r = cyc;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h0, 4'h0, 3'b111, 12'h0);
      setIdle();
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (hReady[d][n+1] !== 1'b1 || hReady[d][n+2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_ready_drop dut%0d: got %b,%b expected 1,0", d, hReady[d][n+1], hReady[d][n+2]);
         end
         seen = 1'b0;
         for (int c = n + 3; c <= r + 19; c++) seen = seen | hValid[d][c] | (|hRValid[d][c]);
         total++;
         if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_dropped dut%0d: got %b expected 0", d, seen);
         end
         total++;
         if (hReady[d][r+15] !== 1'b0 || hReady[d][r+16] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_reclear dut%0d: got %b,%b expected 0,1", d, hReady[d][r+15], hReady[d][r+16]);
         end
         s = r + 21 + lat[d];
         total++;
         if (hValid[d][s] !== 1'b1 || hData[d][s] !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midrst_zeroed dut%0d: got v=%b d=%h expected v=1 d=0", d, hValid[d][s], hData[d][s]);
         end
      end
   endtask

   initial begin
      $display("[TB] starting mem_rtl_mp directed tests");
      test_reset();
      test_clear_reads();
      test_byte_mask();
      test_collision();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
